fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register.
- Generates the PC and issues one request at a time to instruction memory over a valid/ready interface.
- Registers the fetched instruction into IF/ID for decode.
- Directly upstream of the load-use stall detector: consumes its `stall` output (hold IF/ID and PC) and the EX-stage branch/jump redirect (flush).

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset.
- XLEN, 64, PC/address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold request from hazard unit; freezes PC and IF/ID.
- redirect_valid  in  1  taken branch/jump resolved in EX; flush and refetch.
- redirect_pc  in  XLEN  redirect target.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address.
- imem_rsp_valid  in  1  response valid; single cycle, in order, never back-pressured.
- imem_rsp_data  in  32  instruction word.
- ifid_out  out  IFID_Pipe_t  {valid, pc[XLEN-1:0], instr[31:0]} to decode.
- perf_stall_cnt  out  32  stall-cycle counter (optional feature).
- perf_flush_cnt  out  32  redirect counter (optional feature).

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=IDLE, ifid_out.valid=0, ifid_out.pc=0, ifid_out.instr=32'h0000_0013 (NOP).
  - Skid buffer empty; imem_req_valid=0; counters 0.
- At most one outstanding request. FSM states IDLE, WAIT_RSP, DROP.
- IDLE:
  - imem_req_valid=1, imem_req_addr=pc, whenever the skid buffer is empty and no redirect is pending.
  - On accept (valid&&ready): go to WAIT_RSP; latch the in-flight PC.
- WAIT_RSP, on imem_rsp_valid:
  - If stall=0 and IF/ID can advance: load IF/ID {1, inflight_pc, data}; pc += 4; go to IDLE.
  - If stall=1: write the response into the one-entry skid buffer; pc += 4; go to IDLE. IDLE issues no request while the skid buffer is full.
- DROP (entered on redirect while a request is outstanding): discard the next response, then go to IDLE. No request is issued while in DROP.
- Skid buffer drain: the first cycle with stall=0 moves the skid entry into IF/ID. The buffer empties the same cycle and a new request may issue that cycle.
- stall=1 and redirect_valid=0: IF/ID, pc and skid contents hold; an already-issued request completes into the skid buffer.
- redirect_valid=1 (priority over stall):
  - IF/ID.valid<=0 and IF/ID.instr<=NOP next cycle.
  - Skid buffer cleared; pc<=redirect_pc.
  - If in WAIT_RSP with no response this cycle, go to DROP.
  - If a response arrives the same cycle, discard it and go to IDLE.
  - The request to redirect_pc issues no earlier than the cycle after redirect.
- redirect_pc is used as given; bits [1:0] are not masked (misalignment is handled downstream).
- pc increments modulo 2^XLEN (wraps silently).
- Minimum latency: request accepted cycle N, response at N+1, IF/ID valid at N+2.
- imem_req_addr is held stable while imem_req_valid=1 and ready=0.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - perf_stall_cnt increments every cycle with stall=1 && redirect_valid=0.
  - perf_flush_cnt increments every cycle with redirect_valid=1.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: both outputs tied to 0; no counter flops.

Decomposition:
- pipeline_pkg additions:
  - IFID_Pipe_t struct.
  - fetch_state_t enum {IDLE, WAIT_RSP, DROP}.
  - NOP_INSTR = 32'h0000_0013.
  - RESET_PC default constant.
- One sub-module: fetch_skid_buf, a one-entry {pc, instr} buffer with push/pop/clear and a full flag.

Test Plan:
- Reset release, memory ready always, 1-cycle response → requests to 0x8000_0000, 0x8000_0004, …; first IF/ID valid with pc=0x8000_0000 two cycles after first accept.
- stall=1 for 3 cycles while a response arrives → IF/ID holds the old instr; skid holds the new word; no new request; on stall=0, IF/ID gets the skid entry and the next request issues the same cycle.
- redirect_valid=1, redirect_pc=0x8000_0100 while WAIT_RSP → IF/ID.valid=0 next cycle; stale response dropped; next request addr=0x8000_0100.
- redirect_valid and stall both 1 with skid full → redirect wins: skid cleared, IF/ID invalid, pc=redirect_pc.
- imem_req_ready=0 for 4 cycles → imem_req_addr stable, no PC advance.
- With FETCH_PERF_CNT_EN: 5 stall cycles and 2 redirects → perf_stall_cnt=5, perf_flush_cnt=2. Without the macro: both read 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the fetch stage and IF/ID register.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_pkg;

    localparam int          PIPE_XLEN    = 64;
    localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RSP,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic                 valid;
        logic [PIPE_XLEN-1:0] pc;
        logic [31:0]          instr;
    } IFID_Pipe_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instr} holding register for fetch responses that land during a stall.
// Latency: a push shows as full the next cycle; pop or clear empties it the next cycle.
// Backpressure: none internally; the owner never pushes while full. Clear beats push beats pop.
module fetch_skid_buf
    import pipeline_pkg::*;
#(
    parameter int XLEN = PIPE_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [XLEN-1:0] push_pc,
    input  logic [31:0]     push_instr,
    input  logic            pop,
    input  logic            clear,
    output logic            full,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     instr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full  <= 1'b0;
            pc    <= '0;
            instr <= NOP_INSTR;
        end else if (clear) begin
            full <= 1'b0;
        end else if (push) begin
            full  <= 1'b1;
            pc    <= push_pc;
            instr <= push_instr;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch (one outstanding imem request) plus IF/ID register; FETCH_PERF_CNT_EN adds perf counters.
// Latency: request accepted in cycle N, response N+1, IF/ID valid in N+2.
// Backpressure: stall holds PC and IF/ID, late responses park in a skid entry; redirect flushes and wins over stall.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter int            XLEN     = PIPE_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output IFID_Pipe_t      ifid_out,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_flush_cnt
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inflight_pc;
    logic            skid_full;
    logic [XLEN-1:0] skid_pc;
    logic [31:0]     skid_instr;

    logic rsp_hit;
    logic skid_push;
    logic skid_pop;

    assign rsp_hit   = (state == WAIT_RSP) && imem_rsp_valid;
    assign skid_push = rsp_hit && stall && !redirect_valid;
    assign skid_pop  = skid_full && !stall && !redirect_valid;

    // A full skid entry blocks issue, except on the cycle it drains into IF/ID.
    assign imem_req_valid = rst_n && (state == IDLE) && !redirect_valid && (!skid_full || !stall);
    assign imem_req_addr  = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            pc    <= redirect_pc;
            state <= (state != IDLE && !imem_rsp_valid) ? DROP : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (imem_req_valid && imem_req_ready) begin
                        state       <= WAIT_RSP;
                        inflight_pc <= pc;
                    end
                end
                WAIT_RSP: begin
                    if (imem_rsp_valid) begin
                        pc    <= pc + XLEN'(4);
                        state <= IDLE;
                    end
                end
                DROP: begin
                    if (imem_rsp_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_out <= '{valid: 1'b0, pc: '0, instr: NOP_INSTR};
        end else if (redirect_valid) begin
            ifid_out.valid <= 1'b0;
            ifid_out.instr <= NOP_INSTR;
        end else if (!stall) begin
            if (skid_full) begin
                ifid_out <= {1'b1, skid_pc, skid_instr};
            end else if (rsp_hit) begin
                ifid_out <= {1'b1, inflight_pc, imem_rsp_data};
            end else begin
                ifid_out.valid <= 1'b0;
            end
        end
    end

    fetch_skid_buf #(.XLEN(XLEN)) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (skid_push),
        .push_pc    (inflight_pc),
        .push_instr (imem_rsp_data),
        .pop        (skid_pop),
        .clear      (redirect_valid),
        .full       (skid_full),
        .pc         (skid_pc),
        .instr      (skid_instr)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && !redirect_valid && stall_cnt != 32'hFFFF_FFFF) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (redirect_valid && flush_cnt != 32'hFFFF_FFFF) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = stall_cnt;
    assign perf_flush_cnt = flush_cnt;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: memory model with programmable latency, expected IF/ID queue.
module tb_fetch_stage;
    import pipeline_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    IFID_Pipe_t  ifid_out;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .ifid_out       (ifid_out),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] exp_pc     = 64'h0000_0000_8000_0000;
    int          n_chk      = 0;
    int          n_err      = 0;
    int          cyc        = 0;
    int          first_acc  = -1;
    int          first_ifid = -1;
    int          n_pop      = 0;
    int          mem_lat    = 1;
    int          cnt_dn     = 0;
    int          m_stall    = 0;
    int          m_flush    = 0;
    logic [63:0] rsp_addr   = '0;
    logic        acc_seen   = 1'b0;
    IFID_Pipe_t  hold;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0003;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes before the edge, score and drive memory after it.
    task automatic tick();
        logic        p_rst, p_acc, p_stall, p_redir;
        logic [63:0] p_addr, p_rpc;
        exp_t        e;
        #1;
        p_rst   = rst_n;
        p_acc   = imem_req_valid && imem_req_ready;
        p_addr  = imem_req_addr;
        p_stall = stall;
        p_redir = redirect_valid;
        p_rpc   = redirect_pc;
        @(posedge clk);
        #1;
        cyc++;
        acc_seen = 1'b0;
        if (p_rst) begin
            if (p_stall && !p_redir) m_stall++;
            if (p_redir) m_flush++;
            if (p_acc) begin
                check("req_addr", p_addr, exp_pc);
                exp_q.push_back({exp_pc, mem_word(exp_pc)});
                exp_pc = exp_pc + 64'd4;
                if (first_acc < 0) first_acc = cyc;
                acc_seen = 1'b1;
            end
            if (p_redir) begin
                exp_q.delete();
                exp_pc = p_rpc;
                check("flush_valid", 64'(ifid_out.valid), 64'd0);
                check("flush_instr", 64'(ifid_out.instr), 64'(NOP_INSTR));
            end else if (!p_stall && ifid_out.valid) begin
                if (exp_q.size() == 0) begin
                    check("ifid_unexpected", 64'(ifid_out.valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("ifid_pc", ifid_out.pc, e.pc);
                    check("ifid_instr", 64'(ifid_out.instr), 64'(e.instr));
                    n_pop++;
                    if (first_ifid < 0) first_ifid = cyc;
                end
            end
        end
        if (cnt_dn != 0) cnt_dn--;
        if (p_rst && p_acc) begin
            cnt_dn   = mem_lat;
            rsp_addr = p_addr;
        end
        imem_rsp_valid = (cnt_dn == 1);
        imem_rsp_data  = imem_rsp_valid ? mem_word(rsp_addr) : $urandom;
    endtask

    task automatic wait_acc();
        int i;
        i = 0;
        tick();
        while (!acc_seen && i < 20) begin
            tick();
            i++;
        end
        check("wait_acc", 64'(acc_seen), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        repeat (2) tick();
        check("rst_valid", 64'(ifid_out.valid), 64'd0);
        check("rst_pc", ifid_out.pc, 64'd0);
        check("rst_instr", 64'(ifid_out.instr), 64'(NOP_INSTR));
        check("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("rst_perf_stall", 64'(perf_stall_cnt), 64'd0);
        check("rst_perf_flush", 64'(perf_flush_cnt), 64'd0);
        rst_n = 1'b1;

        // Free-running stream from RESET_PC.
        repeat (12) tick();
        check("first_latency", 64'(first_ifid - first_acc), 64'd1);
        check("stream_pops", 64'(n_pop >= 5), 64'd1);

        // Stall while a response arrives: it parks in the skid entry.
        wait_acc();
        hold  = ifid_out;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_no_req", 64'(imem_req_valid), 64'd0);
            check("stall_hold_pc", ifid_out.pc, hold.pc);
            check("stall_hold_instr", 64'(ifid_out.instr), 64'(hold.instr));
        end
        stall = 1'b0;
        #1;
        check("drain_req_valid", 64'(imem_req_valid), 64'd1);
        tick();
        check("drain_issue", 64'(acc_seen), 64'd1);
        repeat (3) tick();

        // Redirect while waiting on a slow response: stale word is dropped.
        mem_lat = 2;
        wait_acc();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_0100;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("drop_no_req", 64'(imem_req_valid), 64'd0);
        tick();
        check("redir_req_valid", 64'(imem_req_valid), 64'd1);
        check("redir_req_addr", imem_req_addr, 64'h0000_0000_8000_0100);
        mem_lat = 1;
        repeat (6) tick();

        // Redirect and stall together with the skid entry full.
        wait_acc();
        stall = 1'b1;
        repeat (2) tick();
        check("skid_full_no_req", 64'(imem_req_valid), 64'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_0200;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("rs_req_valid", 64'(imem_req_valid), 64'd1);
        check("rs_req_addr", imem_req_addr, 64'h0000_0000_8000_0200);
        stall = 1'b0;
        repeat (6) tick();

        // Memory not ready: address and PC hold.
        imem_req_ready = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("nrdy_valid", 64'(imem_req_valid), 64'd1);
            check("nrdy_addr", imem_req_addr, exp_pc);
        end
        imem_req_ready = 1'b1;
        wait_acc();

        // Redirect coinciding with a response, to the top of the address space (wraps).
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("wrap_req_valid", 64'(imem_req_valid), 64'd1);
        check("wrap_req_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        repeat (5) tick();
        check("wrap_exp_pc_low", 64'(exp_pc < 64'h100), 64'd1);

        // Misaligned redirect target is passed through unmasked.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_0302;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("misalign_addr", imem_req_addr, 64'h0000_0000_8000_0302);
        repeat (8) tick();

`ifdef FETCH_PERF_CNT_EN
        check("perf_stall", 64'(perf_stall_cnt), 64'(m_stall));
        check("perf_flush", 64'(perf_flush_cnt), 64'(m_flush));
`else
        check("perf_stall_off", 64'(perf_stall_cnt), 64'd0);
        check("perf_flush_off", 64'(perf_flush_cnt), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
